des_iter_ctrl: RTL and testbench

Sequencing controller for an iterative, area-reduced DES engine. It accepts one 64-bit block, 64-bit key and mode through a valid/ready handshake. It runs the 16 Feistel rounds at one round per clock through a single shared combinational round datapath, driving the C/D key-schedule rotations forward for encryption and backward for decryption. It then presents the result on an output valid/ready handshake. It sits between the system bus adapter and the round logic, replacing the fully unrolled 16-round encrypt/decrypt pair.

---
 rtl/des_pkg.sv | 114 +++++++++++
 rtl/des_round.sv | 23 ++
 rtl/des_iter_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_des_iter_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared constants and helpers for the iterative DES engine.
//   - state_t (IDLE/RUN/DONE) and the mode encoding (MODE_ENC = 1, MODE_DEC = 0)
//   - IP, FP, E, P, PC-1 and PC-2 tables (1-based, bit 1 = MSB), eight S-boxes
//   - SHIFT key-schedule rotation amounts per round
//   - permutation / substitution / rotation helper functions
package des_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    localparam int unsigned SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    localparam int unsigned IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int unsigned FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
    localparam int unsigned E_T [48] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int unsigned P_T [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int unsigned PC1_T [56] = '{
        57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2, 59,51,43,35,27,19,11,3, 60,52,44,36,
        63,55,47,39,31,23,15,7, 62,54,46,38,30,22,14,6, 61,53,45,37,29,21,13,5, 28,20,12,4};
    localparam int unsigned PC2_T [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    // Each box indexed by {row, col} = {b5, b0, b4..b1} of its 6-bit input.
    localparam int unsigned SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int unsigned i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        y = '0;
        for (int unsigned s = 0; s < 8; s++) begin
            six = x[6'(42 - 6 * s) +: 6];
            y[5'(28 - 4 * s) +: 4] = 4'(SBOX[s][{six[5], six[0], six[4:1]}]);
        end
        return y;
    endfunction

    // Schedule amounts are only ever 1 or 2.
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES Feistel round (E expansion, key mix,
// S-boxes, P permutation).
//   l_i, r_i : current halves      k_i : 48-bit round key
//   l_o, r_o : next halves (l_o = r_i, r_o = l_i ^ f(r_i, k_i))
import des_pkg::*;

module des_round (
    input  logic [31:0] l_i,
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] l_o,
    output logic [31:0] r_o
);

    logic [47:0] mix;

    always_comb begin
        mix = e_expand(r_i) ^ k_i;
        l_o = r_i;
        r_o = l_i ^ p_perm(sbox_sub(mix));
    end

endmodule

// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: iterative DES sequencer, one Feistel round per clock.
//   clk, rst_n (async, active low)
//   in_valid/in_ready/in_data/in_key/in_mode : request (in_mode 1 = encrypt)
//   out_valid/out_ready/out_data             : result, held until accepted
//   busy                                      : an operation is in flight
//   abort                                     : only with DES_ITER_CTRL_ABORT_EN;
//                                               synchronous cancel from RUN/DONE
import des_pkg::*;

module des_iter_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
`ifdef DES_ITER_CTRL_ABORT_EN
    ,
    input  logic        abort
`endif
);

    state_t      state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        mode_q, mode_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q, out_data_d;

    logic        abort_req;
    logic [63:0] ip_data;
    logic [55:0] pc1_key;
    logic [27:0] c_rot, d_rot, c_nxt, d_nxt;
    logic [47:0] round_key;
    logic [31:0] l_nxt, r_nxt;
    logic [3:0]  dec_idx;

`ifdef DES_ITER_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign ip_data   = ip_perm(in_data);
    assign pc1_key   = pc1_perm(in_key);
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Decrypt walks the schedule backwards: round 0 uses the loaded C||D
    // (equal to C16||D16), round r >= 1 first rotates right by SHIFT[16-r].
    // That only totals 27, so the last decrypt round adds the SHIFT[0]
    // rotation to leave C||D back at its loaded value.
    always_comb begin
        dec_idx = 4'd0 - round_q;  // 16 - r modulo 16
        if (mode_q == MODE_DEC) begin
            if (round_q == 4'd0) begin
                c_rot = c_q;
                d_rot = d_q;
            end else begin
                c_rot = rotr28(c_q, 2'(SHIFT[dec_idx]));
                d_rot = rotr28(d_q, 2'(SHIFT[dec_idx]));
            end
            if (round_q == 4'd15) begin
                c_nxt = rotr28(c_rot, 2'(SHIFT[0]));
                d_nxt = rotr28(d_rot, 2'(SHIFT[0]));
            end else begin
                c_nxt = c_rot;
                d_nxt = d_rot;
            end
        end else begin
            c_rot = rotl28(c_q, 2'(SHIFT[round_q]));
            d_rot = rotl28(d_q, 2'(SHIFT[round_q]));
            c_nxt = c_rot;
            d_nxt = d_rot;
        end
        round_key = pc2_perm({c_rot, d_rot});
    end

    des_round u_round (
        .l_i (l_q),
        .r_i (r_q),
        .k_i (round_key),
        .l_o (l_nxt),
        .r_o (r_nxt)
    );

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !abort_req) begin
                    l_d     = ip_data[63:32];
                    r_d     = ip_data[31:0];
                    c_d     = pc1_key[55:28];
                    d_d     = pc1_key[27:0];
                    mode_d  = in_mode;
                    round_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_req) begin
                    round_d     = '0;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    l_d     = l_nxt;
                    r_d     = r_nxt;
                    c_d     = c_nxt;
                    d_d     = d_nxt;
                    round_d = round_q + 4'd1;
                    if (round_q == 4'd15) begin
                        out_data_d  = fp_perm({r_nxt, l_nxt});
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (abort_req || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_q     <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifndef SYNTHESIS
    logic [55:0] cd_load_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_load_q <= '0;
        end else if (in_ready && in_valid && !abort_req) begin
            cd_load_q <= pc1_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_q == DONE) begin
            assert ({c_q, d_q} == cd_load_q)
            else $error("des_iter_ctrl: C||D not back at loaded value in DONE");
        end
    end
`endif

endmodule

// File: tb/tb_des_iter_ctrl.sv
// tb_des_iter_ctrl: known-answer vectors plus randomized operations checked
// against a straightforward DES reference (full 16-subkey schedule, reversed
// for decryption).
import des_pkg::*;

module tb_des_iter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
`ifdef DES_ITER_CTRL_ABORT_EN
    logic        abort;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2 = 64'h8787878787878787;
    localparam logic [63:0] C2 = 64'h0000000000000000;

    des_iter_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef DES_ITER_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_des(input logic [63:0] key, input logic [63:0] blk,
                                            input logic enc);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] t, o;
        logic [31:0] l, r, f, sb, tmp;
        logic [47:0] x;
        logic [5:0]  six;
        logic [3:0]  sv;
        cd = '0;
        for (int unsigned i = 0; i < 56; i++) cd = {cd[54:0], key[6'(64 - PC1_T[i])]};
        c = cd[55:28];
        d = cd[27:0];
        for (int unsigned k = 0; k < 16; k++) begin
            for (int unsigned j = 0; j < SHIFT[k]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            ks[k] = '0;
            for (int unsigned i = 0; i < 48; i++) ks[k] = {ks[k][46:0], cd[6'(56 - PC2_T[i])]};
        end
        t = '0;
        for (int unsigned i = 0; i < 64; i++) t = {t[62:0], blk[6'(64 - IP_T[i])]};
        l = t[63:32];
        r = t[31:0];
        for (int unsigned k = 0; k < 16; k++) begin
            x = '0;
            for (int unsigned i = 0; i < 48; i++) x = {x[46:0], r[5'(32 - E_T[i])]};
            x = x ^ (enc ? ks[k] : ks[15 - k]);
            sb = '0;
            for (int unsigned s = 0; s < 8; s++) begin
                six = x[6'(47 - 6 * s) -: 6];
                sv  = 4'(SBOX[s][{six[5], six[0], six[4:1]}]);
                sb  = {sb[27:0], sv};
            end
            f = '0;
            for (int unsigned i = 0; i < 32; i++) f = {f[30:0], sb[5'(32 - P_T[i])]};
            tmp = r;
            r   = l ^ f;
            l   = tmp;
        end
        t = {r, l};
        o = '0;
        for (int unsigned i = 0; i < 64; i++) o = {o[62:0], t[6'(64 - FP_T[i])]};
        return o;
    endfunction

    // One full operation: accept, time the latency, optionally stall DONE
    // with ignored in_valid pulses, then complete the result handshake.
    task automatic do_op(input logic [63:0] key, input logic [63:0] data, input logic mode,
                         input int unsigned stall, input logic [63:0] exp, input string tag);
        int unsigned n;
        in_key    = key;
        in_data   = data;
        in_mode   = mode;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check_eq({tag, "_accept_wait"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_data  = ~data;
        in_key   = ~key;
        in_mode  = ~mode;
        check_eq({tag, "_busy_run"}, 64'(busy), 64'd1);
        check_eq({tag, "_ready_run"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'd16);
        check_eq({tag, "_data"}, out_data, exp);
        for (int unsigned i = 0; i < stall; i++) begin
            in_valid = ((i % 2) == 0);
            tick();
            check_eq({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
            check_eq({tag, "_stall_data"}, out_data, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_post_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_post_data"}, out_data, exp);
    endtask

    initial begin
        int unsigned n;
        logic        seen;
        logic [63:0] key, data, exp;
        logic        mode;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
`ifdef DES_ITER_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

        do_op(K1, P1, MODE_ENC, 0, C1, "kat_enc1");
        do_op(K1, C1, MODE_DEC, 0, P1, "kat_dec1");
        do_op(K2, P2, MODE_ENC, 0, C2, "kat_enc2");
        do_op(K2, P2, MODE_ENC, 10, C2, "kat_stall");

        // Back-to-back with in_valid held high: second acceptance at E18.
        in_key    = K1;
        in_data   = P1;
        in_mode   = MODE_ENC;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_data = C1;
        in_mode = MODE_DEC;
        n    = 0;
        seen = 1'b0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
            if (out_valid) begin
                seen = 1'b1;
                check_eq("b2b_first_data", out_data, C1);
            end
        end
        check_eq("b2b_first_seen", 64'(seen), 64'd1);
        check_eq("b2b_second_accept_edge", 64'(n + 1), 64'd18);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq("b2b_second_latency", 64'(n), 64'd16);
        check_eq("b2b_second_data", out_data, P1);
        tick();

        // Asynchronous reset in the middle of round 7.
        in_key   = K1;
        in_data  = P1;
        in_mode  = MODE_ENC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_out_data", out_data, 64'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_eq("midrst_no_output", 64'(seen), 64'd0);
        do_op(K2, P2, MODE_ENC, 0, C2, "after_rst");

`ifdef DES_ITER_CTRL_ABORT_EN
        in_key   = K1;
        in_data  = P1;
        in_mode  = MODE_ENC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_run_ready", 64'(in_ready), 64'd1);
        check_eq("abort_run_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_eq("abort_no_output", 64'(seen), 64'd0);
        abort    = 1'b1;
        in_valid = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("abort_idle_ready", 64'(in_ready), 64'd1);
        check_eq("abort_idle_busy", 64'(busy), 64'd0);
        do_op(K1, P1, MODE_ENC, 0, C1, "after_abort");
`endif

        for (int unsigned i = 0; i < 12; i++) begin
            key  = {$urandom, $urandom};
            data = {$urandom, $urandom};
            mode = 1'($urandom_range(0, 1));
            exp  = ref_des(key, data, mode);
            do_op(key, data, mode, $urandom_range(0, 3), exp, "rnd");
            do_op(key, exp, ~mode, 0, data, "rnd_inverse");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
